sram_mem_controller: RTL and testbench

- Sequences the MEM-stage load/store requests produced by decode (mem_read / mem_write) onto a 16-bit-wide external asynchronous SRAM.
- Each 32-bit word access is split into two 16-bit half accesses, low half then high half; each half lasts a fixed number of wait cycles.
- While an access is in progress the block deasserts ready, which freezes the pipeline.
- Sits between the MEM stage and the board SRAM pins.

---
 rtl/sram_mem_controller.sv | 131 +++++++++++++
 tb/tb_sram_mem_controller.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sram_mem_controller.sv
// Sequences 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM as two
// timed half accesses (low half, then high half), freezing the pipeline via ready.
module sram_mem_controller #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       address,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  // state | meaning
  // IDLE  | waiting for a request; ready = ~req
  // LO    | low half access, held WAIT_CYCLES cycles
  // HI    | high half access, held WAIT_CYCLES cycles
  // DONE  | one-cycle ready pulse, then back to IDLE
  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  localparam logic [3:0] LP_LAST = 4'(WAIT_CYCLES - 1);

  state_t            r_state, w_next;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr_lo, r_addr_hi;
  logic [31:0]       r_wdata, r_rdata;
  logic              r_op_wr;
  logic              w_req, w_last;
  logic [31:0]       w_off;
  logic [ADDR_W-1:0] w_lo_addr;

  assign w_req     = mem_read | mem_write;
  assign w_off     = address - 32'(BASE_ADDR);
  // halfword address of the low half; upper word bits wrap silently
  assign w_lo_addr = ADDR_W'((w_off >> 2) << 1);
  assign w_last    = (r_cnt == LP_LAST);
  assign rdata     = r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_req)  w_next = S_LO;
      S_LO:   if (w_last) w_next = S_HI;
      S_HI:   if (w_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_addr_lo <= '0;
      r_addr_hi <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_op_wr   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr_lo <= w_lo_addr;
            r_addr_hi <= w_lo_addr | ADDR_W'(1);
            r_wdata   <= wdata;
            r_op_wr   <= mem_write;
            r_cnt     <= '0;
          end
        end
        S_LO: begin
          if (w_last) begin
            r_cnt <= '0;
            if (!r_op_wr) r_rdata[15:0] <= sram_dq_in;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_HI: begin
          if (w_last) begin
            r_cnt <= '0;
            if (!r_op_wr) r_rdata[31:16] <= sram_dq_in;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ready       = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_addr   = r_addr_lo;
    sram_dq_out = r_wdata[15:0];
    case (r_state)
      S_IDLE: ready = ~w_req;
      S_LO: begin
        sram_we_n  = ~r_op_wr;
        sram_oe_n  = r_op_wr;
        sram_dq_oe = r_op_wr;
      end
      S_HI: begin
        sram_we_n   = ~r_op_wr;
        sram_oe_n   = r_op_wr;
        sram_dq_oe  = r_op_wr;
        sram_addr   = r_addr_hi;
        sram_dq_out = r_wdata[31:16];
      end
      S_DONE: ready = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller with a small behavioural SRAM model;
// every access is checked cycle by cycle against hand-derived pin values.
module tb_sram_mem_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;
  logic        sram_oe_n;

  int n_pass = 0;
  int n_total = 0;

  logic [15:0] mem [0:255];

  always #5 clk = ~clk;

  sram_mem_controller #(.ADDR_W(18), .WAIT_CYCLES(2), .BASE_ADDR(1024)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  assign sram_dq_in = mem[sram_addr[7:0]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[2] <= 16'h5678;
      mem[3] <= 16'h1234;
    end else if (!sram_we_n) begin
      mem[sram_addr[7:0]] <= sram_dq_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Called at a falling edge; runs one access and returns at the DONE cycle.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [17:0] exp_lo,
                        input bit from_done, input logic [31:0] exp_rdata);
    int          low;
    logic [17:0] ea;
    logic [15:0] half;
    mem_read  = rd;
    mem_write = wr;
    address   = addr;
    wdata     = wd;
    #1;
    if (from_done) begin
      check("gap_ready", {31'b0, ready}, 32'd1);
      @(negedge clk);
    end
    check("req_ready", {31'b0, ready}, 32'd0);
    low = 1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ready) break;
      low++;
      if (k <= 4) begin
        ea   = (k > 2) ? exp_lo + 18'd1 : exp_lo;
        half = (k > 2) ? wd[31:16] : wd[15:0];
        check("sram_addr", {14'b0, sram_addr}, {14'b0, ea});
        check("we_n", {31'b0, sram_we_n}, {31'b0, ~wr});
        check("oe_n", {31'b0, sram_oe_n}, {31'b0, wr});
        check("dq_oe", {31'b0, sram_dq_oe}, {31'b0, wr});
        if (wr) check("dq_out", {16'b0, sram_dq_out}, {16'b0, half});
      end
    end
    check("low_cycles", low, 5);
    check("done_we_n", {31'b0, sram_we_n}, 32'd1);
    check("done_oe_n", {31'b0, sram_oe_n}, 32'd1);
    check("rdata", rdata, exp_rdata);
  endtask

  task automatic go_idle(input logic [31:0] exp_rdata);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'b0, ready}, 32'd1);
    check("rdata_hold", rdata, exp_rdata);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_we_n", {31'b0, sram_we_n}, 32'd1);
    check("rst_oe_n", {31'b0, sram_oe_n}, 32'd1);
    check("rst_dq_oe", {31'b0, sram_dq_oe}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_addr", {14'b0, sram_addr}, 32'd0);
    check("rst_dq_out", {16'b0, sram_dq_out}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // write 0xDEADBEEF @1024 -> halfwords 0,1
    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 18'd0, 1'b0, 32'd0);
    go_idle(32'd0);
    check("mem0", {16'b0, mem[0]}, 32'h0000BEEF);
    check("mem1", {16'b0, mem[1]}, 32'h0000DEAD);

    // read @1028 -> halfwords 2,3
    access(1'b1, 1'b0, 32'd1028, 32'd0, 18'd2, 1'b0, 32'h12345678);
    go_idle(32'h12345678);

    // back-to-back write then read @1032
    access(1'b0, 1'b1, 32'd1032, 32'h0000AAAA, 18'd4, 1'b0, 32'h12345678);
    access(1'b1, 1'b0, 32'd1032, 32'd0, 18'd4, 1'b1, 32'h0000AAAA);
    go_idle(32'h0000AAAA);

    // reset during the first HI cycle of a write @1040 (halfwords 8,9)
    mem_write = 1'b1;
    address   = 32'd1040;
    wdata     = 32'h11112222;
    repeat (3) @(negedge clk);
    check("pre_rst_we_n", {31'b0, sram_we_n}, 32'd0);
    check("pre_rst_addr", {14'b0, sram_addr}, 32'd9);
    rst_n     = 1'b0;
    mem_write = 1'b0;
    #1;
    check("mid_rst_we_n", {31'b0, sram_we_n}, 32'd1);
    check("mid_rst_dq_oe", {31'b0, sram_dq_oe}, 32'd0);
    check("mid_rst_oe_n", {31'b0, sram_oe_n}, 32'd1);
    check("mid_rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'b0, ready}, 32'd1);

    // ten idle cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle10_ready", {31'b0, ready}, 32'd1);
      check("idle10_we_n", {31'b0, sram_we_n}, 32'd1);
      check("idle10_oe_n", {31'b0, sram_oe_n}, 32'd1);
      check("idle10_addr", {14'b0, sram_addr}, 32'd0);
    end

    // word 2^17 wraps to halfwords 0,1
    access(1'b0, 1'b1, 32'd525312, 32'hCAFEF00D, 18'd0, 1'b0, 32'd0);
    go_idle(32'd0);
    // read and write together executes as a write
    access(1'b1, 1'b1, 32'd1028, 32'h0BADC0DE, 18'd2, 1'b0, 32'd0);
    go_idle(32'd0);
    access(1'b1, 1'b0, 32'd1028, 32'd0, 18'd2, 1'b0, 32'h0BADC0DE);
    access(1'b1, 1'b0, 32'd1024, 32'd0, 18'd0, 1'b1, 32'hCAFEF00D);
    go_idle(32'hCAFEF00D);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
